ps2_cmd_latch: RTL and testbench

//  Parametrised keyboard-command decoder that sits behind the PS/2 byte receiver.

---
 rtl/ps2_cmd_latch_pkg.sv | 37 +++
 rtl/ps2_cmd_latch_match.sv | 36 +++
 rtl/ps2_cmd_latch.sv | 124 ++++++++++++
 tb/tb_ps2_cmd_latch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_cmd_latch_pkg.sv
// Shared scan codes, FSM state encoding and the default command table for the
// PS/2 command latch.
package ps2_cmd_latch_pkg;

   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam logic [7:0] PS2_EXT = 8'hE0;

   localparam logic [7:0] PS2_A = 8'h1C;
   localparam logic [7:0] PS2_Z = 8'h1A;
   localparam logic [7:0] PS2_X = 8'h22;
   localparam logic [7:0] PS2_D = 8'h23;
   localparam logic [7:0] PS2_C = 8'h21;
   localparam logic [7:0] PS2_F = 8'h2B;
   localparam logic [7:0] PS2_V = 8'h2A;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_e;

   // Default table, entry 0 in the LSBs: A->ch0=3, Z->ch0=1, X->ch0=0,
   // D->ch1=1, C->ch1=0, F->ch2=1, V->ch2=0.
   localparam int DEF_NUM_CMD = 7;
   localparam logic [DEF_NUM_CMD*8-1:0] DEF_CMD_CODE =
      {PS2_V, PS2_F, PS2_C, PS2_D, PS2_X, PS2_Z, PS2_A};
   localparam logic [DEF_NUM_CMD*2-1:0] DEF_CMD_CH =
      {2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
   localparam logic [DEF_NUM_CMD*2-1:0] DEF_CMD_VAL =
      {2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd3};

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ps2_cmd_latch_match.sv
// Combinational command-table search; the lowest-index matching entry wins.
module ps2_cmd_latch_match
   import ps2_cmd_latch_pkg::*;
#(
   parameter int NUM_CMD = DEF_NUM_CMD,
   parameter int CH_W    = 2,
   parameter int CHI_W   = 2,
   parameter int IDX_W   = idx_width(NUM_CMD),
   parameter logic [NUM_CMD*8-1:0]     CMD_CODE = DEF_CMD_CODE,
   parameter logic [NUM_CMD*CHI_W-1:0] CMD_CH   = DEF_CMD_CH,
   parameter logic [NUM_CMD*CH_W-1:0]  CMD_VAL  = DEF_CMD_VAL
) (
   input  logic [7:0]       code,
   output logic             hit,
   output logic [IDX_W-1:0] idx,
   output logic [CHI_W-1:0] ch,
   output logic [CH_W-1:0]  val
);

   // Scan from the top so a lower-index match overwrites any higher one.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      ch  = '0;
      val = '0;
      for (int i = NUM_CMD - 1; i >= 0; i--) begin
         if (CMD_CODE[i*8 +: 8] == code) begin
            hit = 1'b1;
            idx = IDX_W'(i);
            ch  = CMD_CH[i*CHI_W +: CHI_W];
            val = CMD_VAL[i*CH_W +: CH_W];
         end
      end
   end

endmodule

// File: rtl/ps2_cmd_latch.sv
// PS/2 command decoder: prefix FSM, prefix timeout and per-channel status latches.
//
//  state      | meaning
//  ST_IDLE    | waiting for a make code or a prefix byte
//  ST_BRK     | F0 seen, next byte is a released key (ignored)
//  ST_EXT     | E0 seen, next byte is an extended make code or F0
//  ST_EXT_BRK | E0 F0 seen, next byte is a released extended key (ignored)
module ps2_cmd_latch
   import ps2_cmd_latch_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int CH_W       = 2,
   parameter int CHI_W      = 2,
   parameter int NUM_CMD    = DEF_NUM_CMD,
   parameter logic [NUM_CMD*8-1:0]     CMD_CODE = DEF_CMD_CODE,
   parameter logic [NUM_CMD*CHI_W-1:0] CMD_CH   = DEF_CMD_CH,
   parameter logic [NUM_CMD*CH_W-1:0]  CMD_VAL  = DEF_CMD_VAL,
   parameter logic [NUM_CH*CH_W-1:0]   CH_INIT  = '0,
   parameter int IGNORE_EXT = 1,
   parameter int PREFIX_TO  = 100000,
   localparam int IDX_W     = idx_width(NUM_CMD)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   output logic [NUM_CH*CH_W-1:0] ch_value,
   output logic                   cmd_hit,
   output logic [IDX_W-1:0]       cmd_idx,
   output logic                   unknown,
   output logic                   proto_err
);

   localparam int CNT_W = $clog2(PREFIX_TO + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(PREFIX_TO - 1);

   ps2_state_e       state, state_nxt;
   logic [CNT_W-1:0] to_cnt;
   logic             lookup, timeout;

   logic             m_hit;
   logic [IDX_W-1:0] m_idx;
   logic [CHI_W-1:0] m_ch;
   logic [CH_W-1:0]  m_val;

   ps2_cmd_latch_match #(
      .NUM_CMD  (NUM_CMD),
      .CH_W     (CH_W),
      .CHI_W    (CHI_W),
      .IDX_W    (IDX_W),
      .CMD_CODE (CMD_CODE),
      .CMD_CH   (CMD_CH),
      .CMD_VAL  (CMD_VAL)
   ) u_match (
      .code (rx_data),
      .hit  (m_hit),
      .idx  (m_idx),
      .ch   (m_ch),
      .val  (m_val)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // A byte always beats a timeout that lands in the same cycle.
   always_comb begin
      state_nxt = state;
      lookup    = 1'b0;
      timeout   = 1'b0;
      if (rx_valid) begin
         case (state)
            ST_IDLE: begin
               if (rx_data == PS2_BRK)      state_nxt = ST_BRK;
               else if (rx_data == PS2_EXT) state_nxt = ST_EXT;
               else                         lookup    = 1'b1;
            end
            ST_EXT: begin
               if (rx_data == PS2_BRK) begin
                  state_nxt = ST_EXT_BRK;
               end else begin
                  state_nxt = ST_IDLE;
                  lookup    = (IGNORE_EXT == 0);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
         timeout   = 1'b1;
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || rx_valid || state == ST_IDLE || timeout)
         to_cnt <= '0;
      else if (to_cnt != {CNT_W{1'b1}})
         to_cnt <= to_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ch_value  <= CH_INIT;
         cmd_idx   <= '0;
         cmd_hit   <= 1'b0;
         unknown   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         cmd_hit   <= lookup && m_hit;
         unknown   <= lookup && !m_hit;
         proto_err <= timeout;
         if (lookup && m_hit) begin
            cmd_idx <= m_idx;
            // Entries aimed past the last channel match but write nothing.
            for (int k = 0; k < NUM_CH; k++) begin
               if (m_ch == CHI_W'(k))
                  ch_value[k*CH_W +: CH_W] <= m_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_cmd_latch.sv
// Directed bench for ps2_cmd_latch with a short prefix timeout.
module tb_ps2_cmd_latch;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [5:0] ch_value;
   logic       cmd_hit;
   logic [2:0] cmd_idx;
   logic       unknown;
   logic       proto_err;

   int errors = 0;
   int checks = 0;

   ps2_cmd_latch #(.PREFIX_TO(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .ch_value  (ch_value),
      .cmd_hit   (cmd_hit),
      .cmd_idx   (cmd_idx),
      .unknown   (unknown),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   // Presents one byte for one edge; returns on the negedge after that edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (ch_value !== 6'b000000 || cmd_idx !== 3'd0 || cmd_hit !== 1'b0 ||
          unknown !== 1'b0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL reset: ch=%b idx=%0d hit=%b unk=%b perr=%b, want 000000/0/0/0/0",
                  ch_value, cmd_idx, cmd_hit, unknown, proto_err);
      end
   endtask

   task automatic test_make_break();
      send_byte(8'h1C);
      checks++;
      if (cmd_hit !== 1'b1 || cmd_idx !== 3'd0 || ch_value !== 6'b000011) begin
         errors++;
         $display("FAIL make_1c: hit=%b idx=%0d ch=%b, want 1/0/000011", cmd_hit, cmd_idx, ch_value);
      end
      send_byte(8'hF0);
      send_byte(8'h1C);
      checks++;
      if (cmd_hit !== 1'b0 || unknown !== 1'b0 || ch_value !== 6'b000011) begin
         errors++;
         $display("FAIL break_1c: hit=%b unk=%b ch=%b, want 0/0/000011", cmd_hit, unknown, ch_value);
      end
   endtask

   task automatic test_multi_channel();
      logic [7:0] codes [3] = '{8'h23, 8'h2B, 8'h1A};
      logic [2:0] idxs  [3] = '{3'd3, 3'd5, 3'd1};
      logic [5:0] vals  [3] = '{6'b000111, 6'b010111, 6'b010101};
      for (int i = 0; i < 3; i++) begin
         send_byte(codes[i]);
         checks++;
         if (cmd_hit !== 1'b1 || cmd_idx !== idxs[i] || ch_value !== vals[i]) begin
            errors++;
            $display("FAIL multi[%0d]: hit=%b idx=%0d ch=%b, want 1/%0d/%b",
                     i, cmd_hit, cmd_idx, ch_value, idxs[i], vals[i]);
         end
      end
   endtask

   task automatic test_unknown();
      send_byte(8'h55);
      checks++;
      if (unknown !== 1'b1 || cmd_hit !== 1'b0 || ch_value !== 6'b010101 || cmd_idx !== 3'd1) begin
         errors++;
         $display("FAIL unknown_55: unk=%b hit=%b ch=%b idx=%0d, want 1/0/010101/1",
                  unknown, cmd_hit, ch_value, cmd_idx);
      end
      @(negedge clk);
      checks++;
      if (unknown !== 1'b0) begin
         errors++;
         $display("FAIL unknown_pulse: unk=%b, want 0", unknown);
      end
   endtask

   task automatic test_extended();
      send_byte(8'hE0);
      send_byte(8'h1C);
      checks++;
      if (cmd_hit !== 1'b0 || unknown !== 1'b0 || ch_value !== 6'b010101) begin
         errors++;
         $display("FAIL ext_make: hit=%b unk=%b ch=%b, want 0/0/010101", cmd_hit, unknown, ch_value);
      end
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h1C);
      checks++;
      if (cmd_hit !== 1'b0 || unknown !== 1'b0 || ch_value !== 6'b010101) begin
         errors++;
         $display("FAIL ext_break: hit=%b unk=%b ch=%b, want 0/0/010101", cmd_hit, unknown, ch_value);
      end
      // Back in IDLE: an unknown code must be looked up.
      send_byte(8'h66);
      checks++;
      if (unknown !== 1'b1) begin
         errors++;
         $display("FAIL ext_idle: unk=%b, want 1", unknown);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'h1C;
      @(negedge clk);
      checks++;
      if (cmd_hit !== 1'b1 || ch_value !== 6'b010111) begin
         errors++;
         $display("FAIL repeat_first: hit=%b ch=%b, want 1/010111", cmd_hit, ch_value);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      checks++;
      if (cmd_hit !== 1'b1 || cmd_idx !== 3'd0 || ch_value !== 6'b010111) begin
         errors++;
         $display("FAIL repeat_second: hit=%b idx=%0d ch=%b, want 1/0/010111", cmd_hit, cmd_idx, ch_value);
      end
   endtask

   task automatic test_timeout();
      int first = -1;
      int pulses = 0;
      send_byte(8'hF0);
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (proto_err === 1'b1) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      checks++;
      if (first != 16 || pulses != 1) begin
         errors++;
         $display("FAIL timeout: first=%0d pulses=%0d, want 16/1", first, pulses);
      end
      send_byte(8'h1A);
      checks++;
      if (cmd_hit !== 1'b1 || cmd_idx !== 3'd1 || ch_value !== 6'b010101) begin
         errors++;
         $display("FAIL after_timeout: hit=%b idx=%0d ch=%b, want 1/1/010101", cmd_hit, cmd_idx, ch_value);
      end
   endtask

   task automatic test_reset_mid_prefix();
      send_byte(8'h1C);
      checks++;
      if (ch_value !== 6'b010111) begin
         errors++;
         $display("FAIL pre_reset: ch=%b, want 010111", ch_value);
      end
      send_byte(8'hF0);
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h1C;
      @(negedge clk);
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      checks++;
      if (ch_value !== 6'b000000 || cmd_idx !== 3'd0 || cmd_hit !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: ch=%b idx=%0d hit=%b, want 000000/0/0", ch_value, cmd_idx, cmd_hit);
      end
      send_byte(8'h1C);
      checks++;
      if (cmd_hit !== 1'b1 || ch_value !== 6'b000011) begin
         errors++;
         $display("FAIL post_reset: hit=%b ch=%b, want 1/000011", cmd_hit, ch_value);
      end
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_multi_channel();
      test_unknown();
      test_extended();
      test_back_to_back();
      send_byte(8'h1A);
      test_timeout();
      test_reset_mid_prefix();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
